// File: rtl/hps_fpga_onchip_arb_pkg.sv
// Shared types and defaults for the HPS/FPGA on-chip RAM arbiter.
package hps_fpga_onchip_arb_pkg;

  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_BE_W      = DEF_DATA_W / 8;
  localparam int DEF_MAX_BURST = 4;

  // Requester indices, also used as the read-return owner tag
  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hps_fpga_onchip_arb_sched.sv
// Bounded-burst round-robin scheduler for two requesters.
// The grant is combinational from the current owner and live requests;
// the owner keeps the RAM for at most MAX_BURST cycles while the other waits.
module hps_fpga_onchip_arb_sched
  import hps_fpga_onchip_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] grant
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  localparam logic [3:0] BURST_SAT   = 4'hF;

  arb_state_t state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       last_q, last_d;
  logic [1:0] gnt;
  logic [3:0] burst_inc;

  assign burst_inc = (burst_q == BURST_SAT) ? burst_q : burst_q + 4'd1;

  // Grant selection plus next owner, burst length and last-served tracking
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    gnt     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) gnt = last_q ? 2'b01 : 2'b10;
        else if (req0)    gnt = 2'b01;
        else if (req1)    gnt = 2'b10;
      end
      OWN0: begin
        if (req0 && (!req1 || burst_q < BURST_LIMIT)) gnt = 2'b01;
        else if (req1)                                gnt = 2'b10;
      end
      OWN1: begin
        if (req1 && (!req0 || burst_q < BURST_LIMIT)) gnt = 2'b10;
        else if (req0)                                gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      state_d = OWN0;
      last_d  = REQ_M0;
      burst_d = (state_q == OWN0) ? burst_inc : 4'd1;
    end else if (gnt[1]) begin
      state_d = OWN1;
      last_d  = REQ_M1;
      burst_d = (state_q == OWN1) ? burst_inc : 4'd1;
    end else begin
      state_d = IDLE;
      burst_d = 4'd0;
    end
  end

  // Scheduler state register; m0 wins the first tie after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= 4'd0;
      last_q  <= REQ_M1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // No access may reach the RAM while reset is held
  assign grant = gnt & {2{~reset}};

endmodule

// File: rtl/hps_fpga_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between the HPS lightweight bridge (m0)
// and an FPGA-fabric master (m1). Read data returns one cycle after accept.
// Optional feature macro: HPS_FPGA_ONCHIP_ARB_PERF_EN enables the
// accepted-access counters and perf_clear; otherwise the counters read 0.
module hps_fpga_onchip_mem_arbiter
  import hps_fpga_onchip_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DEF_BE_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              perf_clear,
  output logic [31:0]       perf_m0_cnt,
  output logic [31:0]       perf_m1_cnt
);

  logic              req0, req1, any_grant, g_read, g_write, rd_accept;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] g_addr, addr_q;
  logic              rd_pend, rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  hps_fpga_onchip_arb_sched #(.MAX_BURST(MAX_BURST)) u_sched (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .grant (grant)
  );

  assign m0_waitrequest = req0 & ~grant[0];
  assign m1_waitrequest = req1 & ~grant[1];
  assign any_grant      = |grant;

  // Granted master's command; a write beats a simultaneous read
  assign g_read    = grant[1] ? m1_read    : m0_read;
  assign g_write   = grant[1] ? m1_write   : m0_write;
  assign g_addr    = grant[1] ? m1_address : m0_address;
  assign rd_accept = any_grant & g_read & ~g_write;

  assign mem_chipselect = any_grant;
  assign mem_write      = any_grant & g_write;
  assign mem_address    = any_grant ? g_addr : addr_q;
  assign mem_byteenable = !any_grant ? '0 : (grant[1] ? m1_byteenable : m0_byteenable);
  assign mem_writedata  = !any_grant ? '0 : (grant[1] ? m1_writedata  : m0_writedata);
  assign mem_clken      = ~reset;

  // Hold the last granted address on idle cycles so the RAM address is stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          addr_q <= '0;
    else if (any_grant) addr_q <= g_addr;
  end

  // Remember who issued the read accepted this cycle; reset drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= REQ_M0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) rd_owner <= grant[1];
    end
  end

  assign m0_readdatavalid = rd_pend & (rd_owner == REQ_M0);
  assign m1_readdatavalid = rd_pend & (rd_owner == REQ_M1);
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

`ifdef HPS_FPGA_ONCHIP_ARB_PERF_EN
  // Accepted-access counters; a clear in the same cycle beats the increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_m0_cnt <= 32'd0;
      perf_m1_cnt <= 32'd0;
    end else if (perf_clear) begin
      perf_m0_cnt <= 32'd0;
      perf_m1_cnt <= 32'd0;
    end else begin
      if (grant[0]) perf_m0_cnt <= perf_m0_cnt + 32'd1;
      if (grant[1]) perf_m1_cnt <= perf_m1_cnt + 32'd1;
    end
  end
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
  assign perf_m0_cnt       = 32'd0;
  assign perf_m1_cnt       = 32'd0;
`endif

endmodule

// File: tb/tb_hps_fpga_onchip_mem_arbiter.sv
// Scoreboard bench for the on-chip RAM arbiter: a RAM model answers the DUT's
// mem_* port, an arbitration/memory reference model predicts each cycle, and a
// separate monitor checks read returns against queued expectations.
module tb_hps_fpga_onchip_mem_arbiter;

  localparam int AW = 13, DW = 64, BW = 8, MAXB = 4, DEPTH = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          mem_chipselect, mem_write, mem_clken;
  logic          perf_clear;
  logic [31:0]   perf_m0_cnt, perf_m1_cnt;

  always #5 clk = ~clk;

  hps_fpga_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .perf_clear(perf_clear), .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt)
  );

  int total = 0;
  int bad = 0;
  int cycleNum = 0;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  function automatic logic [DW-1:0] mergeBytes(logic [DW-1:0] old, logic [DW-1:0] nw,
                                               logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // RAM model: registered address, unregistered output
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= mergeBytes(ram[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata <= ram[mem_address];
    end
  end

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, actual, expected, cycleNum);
    end
  endtask

  // Reference model state
  typedef struct packed { logic [DW-1:0] data; logic [31:0] due; } rd_exp_t;
  rd_exp_t       q0[$], q1[$];
  logic [DW-1:0] refMem [DEPTH];
  logic          prevGranted;
  int            prevOwner, lastServed, run;
  logic [AW-1:0] heldAddr;
  logic [31:0]   cnt0, cnt1;
  logic          dutGrant0, dutGrant1;

  task automatic modelReset();
    prevGranted = 1'b0; prevOwner = 0; lastServed = 1; run = 0;
    heldAddr = '0; cnt0 = '0; cnt1 = '0;
    q0.delete(); q1.delete();
  endtask

  task automatic applyStimulus(int m, logic rd, logic wr, logic [AW-1:0] a,
                               logic [BW-1:0] be, logic [DW-1:0] wd);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  // One clock: predict the grant, check the DUT at the falling edge, update model
  task automatic stepCycle(output logic acc0, output logic acc1);
    logic r0, r1, wr, rd;
    int g;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic [31:0] expP0, expP1;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (r0 && !r1)      g = 0;
    else if (r1 && !r0) g = 1;
    else if (r0 && r1)  g = (prevGranted && run < MAXB) ? prevOwner : 1 - lastServed;
    else                g = -1;
`ifdef HPS_FPGA_ONCHIP_ARB_PERF_EN
    expP0 = cnt0; expP1 = cnt1;
`else
    expP0 = '0; expP1 = '0;
`endif
    dutGrant0 = r0 & ~m0_waitrequest;
    dutGrant1 = r1 & ~m1_waitrequest;
    checkOutput("m0_waitrequest", 64'(m0_waitrequest), 64'(r0 && g != 0));
    checkOutput("m1_waitrequest", 64'(m1_waitrequest), 64'(r1 && g != 1));
    checkOutput("mem_clken", 64'(mem_clken), 64'd1);
    checkOutput("perf_m0_cnt", 64'(perf_m0_cnt), 64'(expP0));
    checkOutput("perf_m1_cnt", 64'(perf_m1_cnt), 64'(expP1));
    checkOutput("mem_chipselect", 64'(mem_chipselect), 64'(g >= 0));
    if (g >= 0) begin
      if (g == 0) begin rd = m0_read; wr = m0_write; a = m0_address; be = m0_byteenable; wd = m0_writedata; end
      else        begin rd = m1_read; wr = m1_write; a = m1_address; be = m1_byteenable; wd = m1_writedata; end
      checkOutput("mem_write", 64'(mem_write), 64'(wr));
      checkOutput("mem_address", 64'(mem_address), 64'(a));
      if (wr) begin
        checkOutput("mem_byteenable", 64'(mem_byteenable), 64'(be));
        checkOutput("mem_writedata", mem_writedata, wd);
        refMem[a] = mergeBytes(refMem[a], wd, be);
      end else if (rd) begin
        if (g == 0) q0.push_back('{data: refMem[a], due: 32'(cycleNum + 1)});
        else        q1.push_back('{data: refMem[a], due: 32'(cycleNum + 1)});
      end
      run = (prevGranted && prevOwner == g) ? run + 1 : 1;
      prevGranted = 1'b1; prevOwner = g; lastServed = g; heldAddr = a;
      if (g == 0) cnt0 = cnt0 + 32'd1; else cnt1 = cnt1 + 32'd1;
    end else begin
      checkOutput("mem_write idle", 64'(mem_write), 64'd0);
      checkOutput("mem_address held", 64'(mem_address), 64'(heldAddr));
      prevGranted = 1'b0; run = 0;
    end
    if (perf_clear) begin cnt0 = '0; cnt1 = '0; end
    acc0 = (g == 0);
    acc1 = (g == 1);
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor, independent of the stimulus flow
  logic    expV0, expV1;
  rd_exp_t e0, e1;
  always @(negedge clk) begin
    if (!reset) begin
      expV0 = (q0.size() > 0) && (q0[0].due == 32'(cycleNum));
      expV1 = (q1.size() > 0) && (q1[0].due == 32'(cycleNum));
      checkOutput("m0_readdatavalid", 64'(m0_readdatavalid), 64'(expV0));
      checkOutput("m1_readdatavalid", 64'(m1_readdatavalid), 64'(expV1));
      if (expV0) begin
        e0 = q0.pop_front();
        checkOutput("m0_readdata", m0_readdata, e0.data);
        checkOutput("m1_readdata non-owner", m1_readdata, 64'd0);
      end
      if (expV1) begin
        e1 = q1.pop_front();
        checkOutput("m1_readdata", m1_readdata, e1.data);
        checkOutput("m0_readdata non-owner", m0_readdata, 64'd0);
      end
    end
  end

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0, '0);
    perf_clear = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("reset m0_readdatavalid", 64'(m0_readdatavalid), 64'd0);
    checkOutput("reset m1_readdatavalid", 64'(m1_readdatavalid), 64'd0);
    checkOutput("reset mem_chipselect", 64'(mem_chipselect), 64'd0);
    checkOutput("reset mem_write", 64'(mem_write), 64'd0);
    checkOutput("reset mem_address", 64'(mem_address), 64'd0);
    checkOutput("reset mem_clken", 64'(mem_clken), 64'd0);
    checkOutput("reset perf_m0_cnt", 64'(perf_m0_cnt), 64'd0);
    checkOutput("reset perf_m1_cnt", 64'(perf_m1_cnt), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one access and hold it until the model says it was taken
  task automatic doAccess(int m, logic rd, logic wr, logic [AW-1:0] a,
                          logic [BW-1:0] be, logic [DW-1:0] wd);
    logic a0, a1, taken;
    taken = 1'b0;
    applyStimulus(m, rd, wr, a, be, wd);
    for (int i = 0; i < 20 && !taken; i++) begin
      stepCycle(a0, a1);
      taken = (m == 0) ? a0 : a1;
    end
    checkOutput("access accepted within bound", 64'(taken), 64'd1);
    applyStimulus(m, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic a0, a1;
  logic pend0, pend1;
  logic [31:0] perfWant0, perfWant1;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; refMem[i] = '0; end
    doReset();

    // Write then read back on m0
    doAccess(0, 0, 1, 13'h0010, 8'hFF, 64'h0123456789ABCDEF);
    doAccess(0, 1, 0, 13'h0010, 8'h00, 64'd0);
    checkOutput("directed m0 rdvalid", 64'(m0_readdatavalid), 64'd1);
    checkOutput("directed m0 rdata", m0_readdata, 64'h0123456789ABCDEF);
    checkOutput("directed m1 rdvalid quiet", 64'(m1_readdatavalid), 64'd0);

    // Partial-lane write from m1
    doAccess(1, 0, 1, 13'h0000, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
    doAccess(1, 1, 0, 13'h0000, 8'h00, 64'd0);
    checkOutput("directed byteenable rdata", m1_readdata, 64'h00000000FFFFFFFF);

    // Illegal read+write: the write lands, no read return
    doAccess(0, 1, 1, 13'h0050, 8'hFF, 64'hDEADBEEFCAFEF00D);
    stepCycle(a0, a1);
    doAccess(0, 1, 0, 13'h0050, 8'h00, 64'd0);
    stepCycle(a0, a1);

    // Contention from IDLE: m0 x4, m1 x4, m0 x4
    doReset();
    applyStimulus(0, 1, 0, 13'h0020, '0, '0);
    applyStimulus(1, 1, 0, 13'h0021, '0, '0);
    for (int k = 0; k < 12; k++) begin
      stepCycle(a0, a1);
      checkOutput("contention m0 grant", 64'(dutGrant0), 64'(((k / 4) % 2) == 0));
      checkOutput("contention m1 grant", 64'(dutGrant1), 64'(((k / 4) % 2) == 1));
    end
    applyStimulus(0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0, '0);
    stepCycle(a0, a1);

    // Back-to-back reads from a lone requester
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 13'(13'h0040 + i), '0, '0);
      stepCycle(a0, a1);
      checkOutput("b2b m1 accept", 64'(dutGrant1), 64'd1);
    end
    applyStimulus(1, 0, 0, '0, '0, '0);
    stepCycle(a0, a1);

    // Reset right after a read is accepted: the return is dropped
    applyStimulus(0, 1, 0, 13'h0010, '0, '0);
    stepCycle(a0, a1);
    doReset();
    stepCycle(a0, a1);

    // Perf counters: 7 m0 + 3 m1 accesses, then clear
    for (int i = 0; i < 7; i++) doAccess(0, 0, 1, 13'(13'h0060 + i), 8'hFF, 64'(i));
    for (int i = 0; i < 3; i++) doAccess(1, 1, 0, 13'(13'h0060 + i), 8'h00, 64'd0);
    stepCycle(a0, a1);
`ifdef HPS_FPGA_ONCHIP_ARB_PERF_EN
    perfWant0 = 32'd7; perfWant1 = 32'd3;
`else
    perfWant0 = 32'd0; perfWant1 = 32'd0;
`endif
    checkOutput("perf m0 after 7", 64'(perf_m0_cnt), 64'(perfWant0));
    checkOutput("perf m1 after 3", 64'(perf_m1_cnt), 64'(perfWant1));
    perf_clear = 1'b1;
    stepCycle(a0, a1);
    perf_clear = 1'b0;
    stepCycle(a0, a1);
    checkOutput("perf m0 cleared", 64'(perf_m0_cnt), 64'd0);
    checkOutput("perf m1 cleared", 64'(perf_m1_cnt), 64'd0);

    // Randomized traffic on a small address window so reads hit earlier writes
    pend0 = 1'b0; pend1 = 1'b0; a0 = 1'b0; a1 = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!pend0 || a0) begin
        pend0 = ($urandom_range(99) < 60);
        if (pend0) begin
          if ($urandom_range(9) < 5) applyStimulus(0, 1, 0, 13'($urandom_range(31)), '0, '0);
          else applyStimulus(0, 0, 1, 13'($urandom_range(31)), 8'($urandom), {$urandom, $urandom});
        end else applyStimulus(0, 0, 0, '0, '0, '0);
      end
      if (!pend1 || a1) begin
        pend1 = ($urandom_range(99) < 60);
        if (pend1) begin
          if ($urandom_range(9) < 5) applyStimulus(1, 1, 0, 13'($urandom_range(31)), '0, '0);
          else applyStimulus(1, 0, 1, 13'($urandom_range(31)), 8'($urandom), {$urandom, $urandom});
        end else applyStimulus(1, 0, 0, '0, '0, '0);
      end
      perf_clear = ($urandom_range(63) == 0);
      stepCycle(a0, a1);
    end
    perf_clear = 1'b0;
    applyStimulus(0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) stepCycle(a0, a1);
    checkOutput("m0 returns drained", 64'(q0.size()), 64'd0);
    checkOutput("m1 returns drained", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hps_fpga_onchip_mem_arbiter.md
# hps_fpga_onchip_mem_arbiter

Two-requester scheduler that shares the single-port 64-bit, 8192-word on-chip RAM between the HPS lightweight bridge (m0) and an FPGA-fabric master (m1). It presents one Avalon-MM pipelined slave per requester, grants at most one access per cycle with bounded-burst round-robin, and drives the RAM's address/byteenable/chipselect/write/clken inputs. Read data returns with fixed latency to the requester that issued the read.

## Interface
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 64, data width
- BE_W, 8, byteenable width (DATA_W/8)
- MAX_BURST, 4, consecutive grants an owner may keep while the other requester waits (1..15)
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDR_W  word address, N in {0,1}
- mN_byteenable  in  BE_W  write byte lanes
- mN_read / mN_write  in  1  request strobes; both high together is illegal
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  one-cycle read-return strobe
- mem_address / mem_byteenable / mem_writedata  out  ADDR_W / BE_W / DATA_W  to RAM
- mem_chipselect, mem_write, mem_clken  out  1  to RAM
- mem_readdata  in  DATA_W  RAM unregistered output
- perf_clear  in  1  synchronous clear of perf counters
- perf_m0_cnt, perf_m1_cnt  out  32  accepted-access counters

## Operation
- FSM states: IDLE, OWN0, OWN1; burst_cnt (4 bits); last_srv (1 bit).
- reqN = mN_read | mN_write. Grant decided combinationally from state and current reqs; mN_waitrequest = reqN & ~grantN.
- IDLE: one requester → grant it; both → grant ~last_srv. Go to OWNg, burst_cnt = 1.
- OWNx: reqx & (~req_other | burst_cnt < MAX_BURST) → keep x, burst_cnt++ (saturating). Else req_other → switch, burst_cnt = 1. Else neither → IDLE.
- last_srv updated to granted index on every accepted access.
- Granted cycle: mem_chipselect = 1, mem_write = granted write, address/byteenable/writedata muxed from granted master. No grant: chipselect = 0, write = 0, address held.
- mem_clken tied 1 after reset.
- Accepted read records owner in rd_owner flop and sets rd_pend; next cycle mN_readdata = mem_readdata, mN_readdatavalid = rd_pend & (rd_owner == N). Non-owner readdata = 0.
- Perf counters increment on each accepted access of their master, wrap at 2^32; perf_clear wins over increment.

## Timing
- Reset values: state IDLE, burst_cnt 0, last_srv 1 (m0 wins first tie), rd_pend 0, all readdatavalid 0, all mem_* 0 except mem_clken 0 during reset, 1 after; perf counters 0.
- Read latency: accept in cycle T → readdatavalid in T+1. Back-to-back reads, one per cycle, full throughput.
- Write in T then read same address in T+1 returns new data.
- Idle requester → 0 waitrequest cycles. Worst-case wait under contention = MAX_BURST cycles.
- Reset mid-operation: pending read return dropped (no readdatavalid); requester reissues.
- Illegal read+write from one master: write takes precedence, no read return.

## Configuration
- HPS_FPGA_ONCHIP_ARB_PERF_EN defined: perf counters and perf_clear active.
- Undefined: counters removed; perf_m0_cnt/perf_m1_cnt drive constant 0, perf_clear ignored; arbitration unchanged.

## Structure
- Shared package hps_fpga_onchip_arb_pkg: state enum (IDLE, OWN0, OWN1), ADDR_W/DATA_W/BE_W defaults, requester index constants.
- One sub-module: hps_fpga_onchip_arb_sched (FSM, burst_cnt, last_srv, grant vector); datapath mux, read-return tracking and counters in top.

## Test plan
- Reset then m0 write addr 0x0010 data 0x0123456789ABCDEF be 0xFF, m0 read 0x0010 next cycle → readdatavalid on m0 in following cycle, data 0x0123456789ABCDEF; m1 readdatavalid stays 0.
- Both request continuously from IDLE, MAX_BURST=4 → grant order m0 x4, m1 x4, m0 x4; each waitrequest high exactly 4 cycles per turn.
- m1 write be 0x0F data 0xFFFFFFFFFFFFFFFF over 0x0 → read returns 0x00000000FFFFFFFF.
- m0 read accepted, reset asserted next cycle → no readdatavalid, all outputs at reset values.
- Single requester m1 issues 10 back-to-back reads → waitrequest 0 throughout, 10 readdatavalid pulses one cycle after each accept.
- With HPS_FPGA_ONCHIP_ARB_PERF_EN: 7 m0 + 3 m1 accesses → counters 7 and 3; perf_clear → 0; macro undefined → both 0.
